banked_operand_mem: RTL and testbench

//  Parametrised multi-channel operand SRAM that generalises the fixed four-bank
//  48-bit vector-operand store. It provides NUM_BANKS independent 1R/1W banks and

---
 rtl/banked_operand_mem.sv | 154 +++++++++++++++
 tb/tb_banked_operand_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/banked_operand_mem.sv
// Multi-bank operand store: NUM_BANKS independent 1R/1W banks with registered,
// write-first reads, a broadcast write path and a post-reset zero-fill sequencer.
module banked_operand_mem #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 48,
  parameter int ADDR_W    = 9,
  parameter int DEPTH     = 512
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_BANKS-1:0]          rd_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]   rd_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   rd_data,
  output logic [NUM_BANKS-1:0]          rd_valid,
  input  logic [NUM_BANKS-1:0]          wr_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          bcast_en,
  output logic                          init_busy,
  output logic                          err_access
);

  localparam logic [0:0]        ST_INIT  = 1'b0;
  localparam logic [0:0]        ST_READY = 1'b1;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

  logic [0:0]                  state_q, state_d;
  logic [ADDR_W-1:0]           init_cnt_q, init_cnt_d;
  logic                        init_busy_q, init_busy_d;
  logic                        err_q, err_d;
  logic [NUM_BANKS*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_BANKS-1:0]        rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]           mem_q [NUM_BANKS][DEPTH];

  logic [NUM_BANKS-1:0]        mem_we_s;
  logic [ADDR_W-1:0]           mem_waddr_s [NUM_BANKS];
  logic [DATA_W-1:0]           mem_wdata_s;
  logic                        any_req_s;

  // Write-port steering: zero-fill in INIT, broadcast or per-bank writes in READY
  always_comb begin
    mem_wdata_s = wr_data;
    mem_we_s    = {NUM_BANKS{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      mem_waddr_s[b] = wr_addr[b*ADDR_W +: ADDR_W];
    end
    case (state_q)
      ST_INIT: begin
        mem_wdata_s = {DATA_W{1'b0}};
        mem_we_s    = {NUM_BANKS{1'b1}};
        for (int b = 0; b < NUM_BANKS; b++) begin
          mem_waddr_s[b] = init_cnt_q;
        end
      end
      ST_READY: begin
        if (bcast_en) begin
          mem_we_s = {NUM_BANKS{1'b1}};
          for (int b = 0; b < NUM_BANKS; b++) begin
            mem_waddr_s[b] = wr_addr[ADDR_W-1:0];
          end
        end else begin
          mem_we_s = wr_en;
        end
      end
      default: begin
        mem_we_s = {NUM_BANKS{1'b0}};
      end
    endcase
  end

  // Sequencer, access-error tracking and read-port next state
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_busy_d = init_busy_q;
    err_d       = err_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = {NUM_BANKS{1'b0}};
    any_req_s   = (|rd_en) | (|wr_en) | bcast_en;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + CNT_ONE;
        if (any_req_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (init_cnt_q == CNT_LAST) begin
          state_d     = ST_READY;
          init_busy_d = 1'b0;
        end else begin
          state_d     = ST_INIT;
          init_busy_d = 1'b1;
        end
      end
      ST_READY: begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (rd_en[b]) begin
            rd_valid_d[b] = 1'b1;
            // A same-address write this edge wins over the stored word
            if (mem_we_s[b] && (mem_waddr_s[b] == rd_addr[b*ADDR_W +: ADDR_W])) begin
              rd_data_d[b*DATA_W +: DATA_W] = wr_data;
            end else begin
              rd_data_d[b*DATA_W +: DATA_W] = mem_q[b][rd_addr[b*ADDR_W +: ADDR_W]];
            end
          end else begin
            rd_valid_d[b] = 1'b0;
          end
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_cnt_d  = {ADDR_W{1'b0}};
        init_busy_d = 1'b1;
      end
    endcase
  end

  // Control and read-output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= {ADDR_W{1'b0}};
      init_busy_q <= 1'b1;
      err_q       <= 1'b0;
      rd_data_q   <= {(NUM_BANKS*DATA_W){1'b0}};
      rd_valid_q  <= {NUM_BANKS{1'b0}};
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_busy_q <= init_busy_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Bank storage; no writes land while reset is held
  always_ff @(posedge clock) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!reset && mem_we_s[b]) begin
        mem_q[b][mem_waddr_s[b]] <= mem_wdata_s;
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign init_busy  = init_busy_q;
  assign err_access = err_q;

endmodule

// File: tb/tb_banked_operand_mem.sv
// Randomised scoreboard bench for banked_operand_mem against an array-based model.
module tb_banked_operand_mem;

  localparam int NB    = 4;
  localparam int DW    = 48;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NB-1:0]    rd_en = '0;
  logic [NB*AW-1:0] rd_addr = '0;
  logic [NB*DW-1:0] rd_data;
  logic [NB-1:0]    rd_valid;
  logic [NB-1:0]    wr_en = '0;
  logic [NB*AW-1:0] wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             bcast_en = 1'b0;
  logic             init_busy;
  logic             err_access;

  banked_operand_mem #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .bcast_en(bcast_en),
    .init_busy(init_busy), .err_access(err_access)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            bank;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic          rst_edge = 1'b0;
  bit            started = 1'b0;
  bit            ready_m = 1'b0;
  bit            err_m = 1'b0;
  bit            hit;
  logic [DW-1:0] mem_m [NB][DEPTH];
  logic [DW-1:0] last_data [NB];
  exp_t          exp_q[$];

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops expected reads when due and checks valid, data and hold behaviour
  always @(negedge clock) begin
    if (started) begin
      if (rst_edge) begin
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_busy", 64'(init_busy), 64'd1);
        check("rst_err", 64'(err_access), 64'd0);
        for (int b = 0; b < NB; b++) begin
          check($sformatf("rst_data%0d", b), 64'(rd_data[b*DW +: DW]), 64'd0);
          last_data[b] = '0;
        end
      end else begin
        for (int b = 0; b < NB; b++) begin
          hit = (exp_q.size() > 0) && (exp_q[0].bank == b) && (exp_q[0].due == cyc);
          check($sformatf("valid%0d", b), 64'(rd_valid[b]), 64'(hit));
          if (hit) begin
            check($sformatf("data%0d", b), 64'(rd_data[b*DW +: DW]), 64'(exp_q[0].data));
            last_data[b] = exp_q[0].data;
            void'(exp_q.pop_front());
          end else begin
            check($sformatf("hold%0d", b), 64'(rd_data[b*DW +: DW]), 64'(last_data[b]));
          end
        end
      end
    end
  end

  function automatic logic [NB*AW-1:0] addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                            input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Drive one edge; in READY, queue the expected read data from the model, then update it
  task automatic do_cycle(input logic [NB-1:0] re, input logic [NB*AW-1:0] ra,
                          input logic [NB-1:0] we, input logic [NB*AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic bc);
    logic          weff;
    logic [AW-1:0] wad;
    logic [AW-1:0] rad;
    exp_t          e;
    rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; bcast_en = bc;
    if (ready_m) begin
      for (int b = 0; b < NB; b++) begin
        weff = bc | we[b];
        wad  = bc ? wa[AW-1:0] : wa[b*AW +: AW];
        rad  = ra[b*AW +: AW];
        if (re[b]) begin
          e.bank = b;
          e.data = (weff && (wad == rad)) ? wd : mem_m[b][rad];
          e.due  = cyc + 1;
          exp_q.push_back(e);
        end
      end
      for (int b = 0; b < NB; b++) begin
        weff = bc | we[b];
        wad  = bc ? wa[AW-1:0] : wa[b*AW +: AW];
        if (weff) mem_m[b][wad] = wd;
      end
    end else if ((|re) || (|we) || bc) begin
      err_m = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle('0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic rand_cycle(input int amax);
    logic [NB*AW-1:0] ra;
    logic [NB*AW-1:0] wa;
    logic [63:0]      r64;
    for (int b = 0; b < NB; b++) begin
      ra[b*AW +: AW] = AW'($urandom_range(0, amax));
      wa[b*AW +: AW] = AW'($urandom_range(0, amax));
    end
    r64 = {$urandom, $urandom};
    do_cycle(NB'($urandom), ra, NB'($urandom), wa, r64[DW-1:0], ($urandom_range(0, 7) == 0));
  endtask

  // Reset with reads still requested, so any in-flight/new reads must be discarded
  task automatic do_reset(input int n);
    reset = 1'b1;
    rd_en = '1; rd_addr = addrs(9'h005, 9'h005, 9'h044, 9'h044);
    wr_en = '0; bcast_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      started = 1'b1;
      @(negedge clock);
      #1;
    end
    reset = 1'b0;
    rd_en = '0;
    ready_m = 1'b0;
    err_m = 1'b0;
    exp_q.delete();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mem_m[b][a] = '0;
  endtask

  task automatic wait_init(input int pulse_at);
    int n;
    n = 0;
    while (init_busy && n < 2000) begin
      rd_en = (n == pulse_at) ? 4'b0001 : 4'b0000;
      if (n == pulse_at) err_m = 1'b1;
      @(posedge clock);
      @(negedge clock);
      #1;
      n++;
    end
    rd_en = '0;
    check("init_len", 64'(n), 64'(DEPTH));
    ready_m = 1'b1;
  endtask

  initial begin
    do_reset(2);
    wait_init(-1);
    check("err_clean", 64'(err_access), 64'(err_m));

    do_cycle(4'b0100, addrs(9'h0, 9'h0, 9'h1FF, 9'h0), '0, '0, '0, 1'b0);
    idle(1);

    do_cycle('0, '0, 4'b0010, addrs(9'h0, 9'h005, 9'h0, 9'h0), 48'hABCD_1234_5678, 1'b0);
    do_cycle(4'b1111, addrs(9'h005, 9'h005, 9'h005, 9'h005), '0, '0, '0, 1'b0);
    idle(1);

    do_cycle(4'b1000, addrs(9'h0, 9'h0, 9'h0, 9'h010), 4'b1000, addrs(9'h0, 9'h0, 9'h0, 9'h010),
             48'h1, 1'b0);
    idle(1);

    do_cycle('0, '0, 4'b0010, addrs(9'h044, 9'h020, 9'h0, 9'h0), 48'h7777, 1'b1);
    do_cycle(4'b1111, addrs(9'h044, 9'h044, 9'h044, 9'h044), '0, '0, '0, 1'b0);
    do_cycle(4'b0010, addrs(9'h0, 9'h020, 9'h0, 9'h0), '0, '0, '0, 1'b0);
    idle(1);

    // Broadcast read-collision on one bank
    do_cycle(4'b0100, addrs(9'h0, 9'h0, 9'h0AA, 9'h0), 4'b0001, addrs(9'h0AA, 9'h0, 9'h0, 9'h0),
             48'h5A5A_0000_BEEF, 1'b1);

    for (int i = 0; i < 400; i++) rand_cycle(15);
    for (int i = 0; i < 100; i++) rand_cycle(DEPTH - 1);
    idle(2);
    check("err_ready", 64'(err_access), 64'(err_m));

    for (int i = 0; i < 5; i++)
      do_cycle(4'b1111, addrs(AW'(i), AW'(i + 1), AW'(i + 2), AW'(i + 3)), '0, '0, '0, 1'b0);
    do_reset(1);
    wait_init(100);
    check("err_sticky", 64'(err_access), 64'(err_m));

    do_cycle(4'b1111, addrs(9'h044, 9'h005, 9'h044, 9'h010), '0, '0, '0, 1'b0);
    do_cycle(4'b1111, addrs(9'h0AA, 9'h044, 9'h005, 9'h044), '0, '0, '0, 1'b0);
    for (int i = 0; i < 100; i++) rand_cycle(15);
    idle(2);
    check("err_hold", 64'(err_access), 64'(err_m));

    do_reset(2);
    wait_init(-1);
    check("err_cleared", 64'(err_access), 64'(err_m));
    for (int i = 0; i < 50; i++) rand_cycle(7);
    idle(2);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
